// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss handler that fetches one cache block from main memory
// as back-to-back word reads. Each returned word is streamed into the data
// array, and the tag is written together with the final word.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [15:0]       fill_data,
  output logic [15:0]       fill_count
);

  // A block holds WORDS_PER_BLOCK 2-byte words, so the byte offset inside a
  // block is log2(words)+1 bits wide. The counters use the same width so they
  // can reach WORDS_PER_BLOCK itself.
  localparam int                OFF_W = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int                CNT_W = OFF_W;
  localparam logic [CNT_W-1:0]  WPB   = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] ALIGN = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  issueCnt, recvCnt;
  logic [ADDR_W-1:0] base, memAddr;
  logic [15:0]       fillCnt;
  logic              issue, dataWr, lastWord;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state plus request and return decode. A return counts only when it
  // matches an outstanding request, so stray valids never write the array.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    dataWr    = 1'b0;
    lastWord  = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) stateNext = FILL;
      end
      FILL: begin
        issue    = (issueCnt < WPB);
        dataWr   = memory_data_valid && (recvCnt < issueCnt);
        lastWord = dataWr && (recvCnt == LAST);
        if (lastWord) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: block base, request address, counters, saturating fill count.
  // The request address is loaded with the base on the miss, then stepped
  // after each request. It stops stepping at the last word, so it holds that
  // address once all requests have gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      memAddr  <= '0;
      issueCnt <= '0;
      recvCnt  <= '0;
      fillCnt  <= '0;
    end else if (state == IDLE) begin
      if (miss_detected) begin
        base     <= miss_address & ALIGN;
        memAddr  <= miss_address & ALIGN;
        issueCnt <= '0;
        recvCnt  <= '0;
      end
    end else begin
      if (issue) begin
        issueCnt <= issueCnt + 1'b1;
        if (issueCnt != LAST) memAddr <= memAddr + ADDR_W'(2);
      end
      if (dataWr) recvCnt <= recvCnt + 1'b1;
      if (lastWord && fillCnt != 16'hFFFF) fillCnt <= fillCnt + 16'd1;
    end
  end

  assign fsm_busy         = (state == FILL);
  assign mem_read_en      = issue;
  assign memory_address   = memAddr;
  assign write_data_array = dataWr;
  assign write_tag_array  = lastWord;
  assign fill_address     = base + (ADDR_W'(recvCnt) << 1);
  assign fill_data        = memory_data;
  assign fill_count       = fillCnt;

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between one L1 cache (I or D) and the multi-cycle main memory. When the cache reports a miss, it fetches the whole 16-byte block as eight 2-byte word reads. It streams each returned word into the cache data array, then writes the tag on the last word. The pipeline stalls while `fsm_busy` is high. The bench-level miss and hit statistics count the cycles this block spends filling.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, default 8: words fetched per miss (power of two, ≥2).
- `ADDR_W`, default 16: byte-address width.

Ports:
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `miss_detected` input 1: cache tag-check miss this cycle.
- `miss_address` input ADDR_W: byte address that missed.
- `memory_data_valid` input 1: main memory returns a word this cycle.
- `memory_data` input 16: returned word.
- `fsm_busy` output 1: fill in progress; the pipeline stalls on `miss_detected | fsm_busy`.
- `mem_read_en` output 1: read request to memory this cycle.
- `memory_address` output ADDR_W: request byte address.
- `write_data_array` output 1: write `fill_data` into the cache line at `fill_address`.
- `write_tag_array` output 1: write the tag/valid bit of the block containing `fill_address`.
- `fill_address` output ADDR_W: byte address of the word being written into the cache.
- `fill_data` output 16: equals `memory_data` (pass-through).
- `fill_count` output 16: completed fills since reset, saturating at 0xFFFF.

## Operation
- Two states: IDLE and FILL.
- IDLE:
  - `fsm_busy`, `mem_read_en`, `write_data_array` and `write_tag_array` are 0.
  - `memory_data_valid` is ignored.
  - When `miss_detected` is 1: latch `base = miss_address` with the low log2(WORDS_PER_BLOCK)+1 bits cleared, clear `issue_cnt` and `recv_cnt`, and go to FILL.
- FILL, `fsm_busy` = 1:
  - Requests: while `issue_cnt < WORDS_PER_BLOCK`, drive `mem_read_en` = 1 and `memory_address = base + 2*issue_cnt`, then increment `issue_cnt`. Afterwards `mem_read_en` = 0 and `memory_address` holds its last value.
  - Returns: on `memory_data_valid` with `recv_cnt < issue_cnt`, drive `write_data_array` = 1 and `fill_address = base + 2*recv_cnt`, then increment `recv_cnt`.
  - A valid with nothing outstanding (`recv_cnt == issue_cnt`) is ignored and causes no array write.
  - Last word: on the valid for `recv_cnt == WORDS_PER_BLOCK-1`, assert `write_tag_array` = 1 in the same cycle as the final `write_data_array`. Next state is IDLE and `fill_count` increments, saturating.
- `miss_detected` is ignored during FILL. The stalled access re-checks the cache after the fill and hits.
- Address arithmetic is modulo 2^ADDR_W. A block at 0xFFF0 fills 0xFFF0..0xFFFE with no wrap inside the block, because the base is aligned.
- `write_data_array`, `write_tag_array` and `fill_address` are combinational from state, counters and `memory_data_valid`. `fsm_busy`, `mem_read_en` and `memory_address` depend only on registers.

## Timing
- Reset sets: state IDLE, counters 0, `base` 0, `memory_address` 0, `fill_count` 0. Every output is 0, including `fill_address` and `fill_data`, provided `memory_data` is 0.
- Reset during FILL aborts the fill: no tag write, `fill_count` unchanged. Memory returns still in flight are ignored because the state is IDLE.
- `miss_detected` is sampled at edge E0. `fsm_busy` rises in the cycle after E0 (cycle 1).
- Requests go out in cycles 1..8, one per cycle and back-to-back.
- With a memory latency of L cycles (request in cycle c, valid in cycle c+L): data writes occur in cycles 1+L..8+L, and the tag write in cycle 8+L.
- `fsm_busy` falls in cycle 9+L. For L=4, busy lasts 12 cycles.
- A new miss may be accepted in the first IDLE cycle, giving back-to-back fills with 1 IDLE cycle between them.
- Returns may have gaps or be bursty. Correctness depends only on valid ordering, not on L.

## Test plan
- Single miss at 0x1234, memory with L=4: requests 0x1230..0x123E in cycles 1..8. Writes to 0x1230..0x123E carry the memory data in cycles 5..12. Tag write in cycle 12 only. `fsm_busy` high in cycles 1..12. `fill_count` = 1.
- Stray returns: valid pulses in IDLE and after the 8th return → no `write_data_array`, state unchanged.
- Irregular latency: returns at random gaps of 0–3 cycles → exactly 8 in-order data writes, tag write on the 8th, busy falls the cycle after.
- Reset in cycle 6 of a fill to 0xFFF0 → all outputs 0 the next cycle. The remaining returns cause no writes. `fill_count` unchanged. A new miss at 0x0008 then fills 0x0000..0x000E.
- Back-to-back misses to 0x0100 then 0x0200, with `miss_detected` held high throughout → the second miss is taken one cycle after the first busy falls. `fill_count` = 2. A held miss during FILL does not restart the fill.
- Saturation: preload `fill_count` to 0xFFFE by force, then run two fills → 0xFFFF, 0xFFFF.
